game_turn_ctrl: RTL and testbench

- Parametrised multi-player turn controller for the chicken board game.
- Successor to the single-player control FSM: adds N players, configurable board length, key-release qualification, a press timeout, an abort input and per-player position tracking.
- Sits between the keypad decoder and the card-match/display logic.
- Sequences select → press → check → advance/miss → win.

---
 rtl/game_turn_if.sv | 38 +++
 rtl/game_turn_ctrl.sv | 149 ++++++++++++++
 tb/tb_game_turn_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/game_turn_if.sv
// Bundle between the turn controller and the keypad and card-match blocks.
// match is sampled only while match_valid=1; there is no ready, CHECK waits for match_valid.
interface game_turn_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int KEY_W       = 4,
  parameter int BOARD_LEN   = 7
);
  localparam int PLAYER_W = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int POS_W    = $clog2(BOARD_LEN + 1);

  logic                         start;
  logic                         abort;
  logic [KEY_W-1:0]             key;
  logic                         match_valid;
  logic                         match;
  logic [2:0]                   state;
  logic [KEY_W-1:0]             sel_num;
  logic [KEY_W-1:0]             card;
  logic                         reveal;
  logic [PLAYER_W-1:0]          cur_player;
  logic [POS_W-1:0]             cur_pos;
  logic [NUM_PLAYERS*POS_W-1:0] pos_flat;
  logic                         timeout;
  logic                         game_over;
  logic [PLAYER_W-1:0]          winner;

  modport slave (
    input  start, abort, key, match_valid, match,
    output state, sel_num, card, reveal, cur_player, cur_pos, pos_flat,
           timeout, game_over, winner
  );

  modport master (
    output start, abort, key, match_valid, match,
    input  state, sel_num, card, reveal, cur_player, cur_pos, pos_flat,
           timeout, game_over, winner
  );
endinterface

// File: rtl/game_turn_ctrl.sv
// Multi-player turn controller: select -> press -> check -> advance/miss -> win,
// with key-release qualification, optional press timeout and abort.
module game_turn_ctrl #(
  parameter int               NUM_PLAYERS = 2,
  parameter int               KEY_W       = 4,
  parameter logic [KEY_W-1:0] KEY_NONE    = 4'hF,
  parameter int               BOARD_LEN   = 7,
  parameter int               TIMEOUT_CYC = 0
) (
  input logic        CLK,
  input logic        rst,
  game_turn_if.slave bus
);
  localparam int PLAYER_W = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int POS_W    = $clog2(BOARD_LEN + 1);
  localparam int TW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0]       T_LAST   = TW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic [PLAYER_W-1:0] LAST_PL  = PLAYER_W'(NUM_PLAYERS - 1);
  localparam logic [POS_W-1:0]    WIN_POS  = POS_W'(BOARD_LEN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    ARM     = 3'd2,
    PRESS   = 3'd3,
    CHECK   = 3'd4,
    ADVANCE = 3'd5,
    MISS    = 3'd6,
    WIN     = 3'd7
  } state_t;

  state_t                       state_q, state_d;
  logic [KEY_W-1:0]             sel_q, sel_d, card_q, card_d;
  logic [PLAYER_W-1:0]          cur_q, cur_d, winner_q, winner_d;
  logic [NUM_PLAYERS*POS_W-1:0] pos_q, pos_d;
  logic [TW-1:0]                timer_q, timer_d;
  logic                         armed_q, armed_d;
  logic                         reveal_q, reveal_d, timeout_q, timeout_d;
  logic                         key_valid, accept;
  logic [POS_W-1:0]             cur_pos, pos_nxt;

  assign key_valid = (bus.key != KEY_NONE);
  assign accept    = key_valid && armed_q && !bus.abort &&
                     ((state_q == SELECT) || (state_q == PRESS));
  assign cur_pos   = pos_q[int'(cur_q)*POS_W +: POS_W];
  assign pos_nxt   = (cur_pos == WIN_POS) ? cur_pos : cur_pos + 1'b1;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    card_d    = card_q;
    cur_d     = cur_q;
    winner_d  = winner_q;
    pos_d     = pos_q;
    timer_d   = timer_q;
    reveal_d  = 1'b0;
    timeout_d = 1'b0;
    // Re-arming on release is what stops a held key from counting twice.
    armed_d   = !key_valid ? 1'b1 : (accept ? 1'b0 : armed_q);

    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          pos_d    = '0;
          cur_d    = '0;
          sel_d    = '0;
          card_d   = '0;
          winner_d = '0;
          if (bus.start) state_d = SELECT;
        end
        SELECT: if (accept) begin
          sel_d   = bus.key;
          state_d = ARM;
        end
        ARM: begin
          timer_d = '0;
          state_d = PRESS;
        end
        PRESS: begin
          if (accept) begin
            card_d   = bus.key;
            reveal_d = 1'b1;
            state_d  = CHECK;
          end else if ((TIMEOUT_CYC != 0) && (timer_q == T_LAST)) begin
            timeout_d = 1'b1;
            state_d   = MISS;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        CHECK: if (bus.match_valid) state_d = bus.match ? ADVANCE : MISS;
        ADVANCE: begin
          pos_d[int'(cur_q)*POS_W +: POS_W] = pos_nxt;
          if (pos_nxt == WIN_POS) begin
            winner_d = cur_q;
            state_d  = WIN;
          end else begin
            state_d = ARM;
          end
        end
        MISS: begin
          cur_d   = (cur_q == LAST_PL) ? '0 : cur_q + 1'b1;
          state_d = ARM;
        end
        WIN: if (bus.start) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      card_q    <= '0;
      cur_q     <= '0;
      winner_q  <= '0;
      pos_q     <= '0;
      timer_q   <= '0;
      armed_q   <= 1'b0;
      reveal_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      card_q    <= card_d;
      cur_q     <= cur_d;
      winner_q  <= winner_d;
      pos_q     <= pos_d;
      timer_q   <= timer_d;
      armed_q   <= armed_d;
      reveal_q  <= reveal_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.sel_num    = sel_q;
  assign bus.card       = card_q;
  assign bus.reveal     = reveal_q;
  assign bus.cur_player = cur_q;
  assign bus.cur_pos    = cur_pos;
  assign bus.pos_flat   = pos_q;
  assign bus.timeout    = timeout_q;
  assign bus.game_over  = (state_q == WIN);
  assign bus.winner     = winner_q;
endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed bench for game_turn_ctrl: 3 players, board length 2, 4-cycle press timeout.
module tb_game_turn_ctrl;
  logic CLK;
  logic rst;
  int   checks;
  int   errors;
  int   reveal_cnt;

  game_turn_if #(.NUM_PLAYERS(3), .KEY_W(4), .BOARD_LEN(2)) bus ();

  game_turn_ctrl #(
    .NUM_PLAYERS(3), .KEY_W(4), .KEY_NONE(4'hF), .BOARD_LEN(2), .TIMEOUT_CYC(4)
  ) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"},   32'(bus.state), 0);
    chk({tag, "_sel"},     32'(bus.sel_num), 0);
    chk({tag, "_card"},    32'(bus.card), 0);
    chk({tag, "_reveal"},  32'(bus.reveal), 0);
    chk({tag, "_player"},  32'(bus.cur_player), 0);
    chk({tag, "_pos"},     32'(bus.pos_flat), 0);
    chk({tag, "_timeout"}, 32'(bus.timeout), 0);
    chk({tag, "_over"},    32'(bus.game_over), 0);
    chk({tag, "_winner"},  32'(bus.winner), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reveal_cnt = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.key = 4'hF;
    bus.match_valid = 1'b0;
    bus.match = 1'b0;
    #12;
    chk_all_zero("reset");
    #10 rst = 1'b1;
    step();

    // start, select 3, arm, press
    bus.start = 1'b1; step();
    chk("sel_state", 32'(bus.state), 1);
    bus.start = 1'b0; bus.key = 4'h3; step();
    chk("arm_state", 32'(bus.state), 2);
    chk("sel_num", 32'(bus.sel_num), 3);
    bus.key = 4'hF; step();
    chk("press_state", 32'(bus.state), 3);
    chk("press_reveal", 32'(bus.reveal), 0);
    chk("press_card", 32'(bus.card), 0);

    // held key: one reveal only
    bus.key = 4'h5; step();
    chk("held_reveal", 32'(bus.reveal), 1);
    chk("held_card", 32'(bus.card), 5);
    chk("held_state", 32'(bus.state), 4);
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus.reveal === 1'b1) reveal_cnt++;
    end
    chk("held_extra_reveals", 32'(reveal_cnt), 0);
    bus.match = 1'b1; step();
    chk("check_ignores_match", 32'(bus.state), 4);

    // miss: player 0 -> 1, then second reveal after release
    bus.key = 4'hF; bus.match_valid = 1'b1; bus.match = 1'b0; step();
    chk("miss_state", 32'(bus.state), 6);
    chk("miss_no_timeout", 32'(bus.timeout), 0);
    bus.match_valid = 1'b0; step();
    chk("rot_p1", 32'(bus.cur_player), 1);
    step();
    bus.key = 4'h5; step();
    chk("second_reveal", 32'(bus.reveal), 1);
    chk("second_state", 32'(bus.state), 4);

    // miss: player 1 -> 2
    bus.key = 4'hF; bus.match_valid = 1'b1; step();
    bus.match_valid = 1'b0; step();
    chk("rot_p2", 32'(bus.cur_player), 2);
    step();
    bus.key = 4'h7; step();
    chk("p2_card", 32'(bus.card), 7);

    // miss: player 2 wraps to 0
    bus.key = 4'hF; bus.match_valid = 1'b1; step();
    bus.match_valid = 1'b0; step();
    chk("rot_wrap", 32'(bus.cur_player), 0);
    chk("rot_pos", 32'(bus.pos_flat), 0);
    step();
    chk("p0_press", 32'(bus.state), 3);

    // timeout for player 0
    step(); step(); step();
    chk("to_still_press", 32'(bus.state), 3);
    chk("to_not_yet", 32'(bus.timeout), 0);
    step();
    chk("to_pulse", 32'(bus.timeout), 1);
    chk("to_miss", 32'(bus.state), 6);
    step();
    chk("to_pulse_end", 32'(bus.timeout), 0);
    chk("to_player", 32'(bus.cur_player), 1);

    // key on expiry cycle wins over timeout (player 1)
    step();
    step(); step(); step();
    bus.key = 4'h9; step();
    chk("expiry_reveal", 32'(bus.reveal), 1);
    chk("expiry_no_timeout", 32'(bus.timeout), 0);
    chk("expiry_card", 32'(bus.card), 9);

    // player 1 matches twice and wins
    bus.key = 4'hF; bus.match_valid = 1'b1; bus.match = 1'b1; step();
    chk("adv_state", 32'(bus.state), 5);
    bus.match_valid = 1'b0; step();
    chk("adv1_pos", 32'(bus.pos_flat), 32'h4);
    chk("adv1_curpos", 32'(bus.cur_pos), 1);
    chk("adv1_player", 32'(bus.cur_player), 1);
    chk("adv1_state", 32'(bus.state), 2);
    step();
    bus.key = 4'h2; step();
    bus.key = 4'hF; bus.match_valid = 1'b1; step();
    bus.match_valid = 1'b0; step();
    chk("win_state", 32'(bus.state), 7);
    chk("win_over", 32'(bus.game_over), 1);
    chk("win_winner", 32'(bus.winner), 1);
    chk("win_pos", 32'(bus.pos_flat), 32'h8);
    chk("win_curpos", 32'(bus.cur_pos), 2);
    step();
    chk("win_hold", 32'(bus.state), 7);
    bus.start = 1'b1; step();
    chk("win_to_idle", 32'(bus.state), 0);
    chk("idle_over", 32'(bus.game_over), 0);
    bus.start = 1'b0; step();
    chk_all_zero("idle_clear");

    // abort from CHECK
    bus.start = 1'b1; step();
    bus.start = 1'b0; bus.key = 4'h4; step();
    bus.key = 4'hF; step();
    bus.key = 4'h6; step();
    chk("abort_pre", 32'(bus.state), 4);
    bus.key = 4'hF; bus.abort = 1'b1; step();
    chk("abort_idle", 32'(bus.state), 0);
    bus.abort = 1'b0; step();

    // async reset in ADVANCE
    bus.start = 1'b1; step();
    bus.start = 1'b0; bus.key = 4'h1; step();
    bus.key = 4'hF; step();
    bus.key = 4'h8; step();
    bus.key = 4'hF; bus.match_valid = 1'b1; bus.match = 1'b1; step();
    chk("rst_pre_adv", 32'(bus.state), 5);
    bus.match_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge CLK);
    #3 rst = 1'b1;
    step();
    chk("post_rst_state", 32'(bus.state), 0);
    chk("post_rst_pos", 32'(bus.pos_flat), 0);
    bus.start = 1'b1; step();
    chk("post_rst_start", 32'(bus.state), 1);
    bus.start = 1'b0; step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
